hex_display_scan: RTL and testbench

Parametrised multiplexed hex display driver for common-anode 7-segment banks. It is the successor to the fixed 4-digit scanner and adds configurable digit count and scan rate, frame-synchronous double-buffered value updates, 16-level PWM brightness, per-digit blink and leading-zero blanking. It sits between the board's display pins (`seg`/`dp`/`an`) and any value producer in the fabric.

---
 rtl/hex_display_scan.sv | 152 +++++++++++++++
 tb/tb_hex_display_scan.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - multiplexed hex 7-segment scanner with buffered updates, PWM, blink and zero blanking
module hex_display_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 256,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   in_val,
    input  logic [DIGITS-1:0]     in_dot,
    input  logic [DIGITS-1:0]     in_blink,
    input  logic                  blank_lz,
    input  logic [3:0]            bright,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done,
    output logic                  upd_ack
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [DW-1:0]         r_div_cnt;
    logic [IW-1:0]         r_idx;
    logic [FW-1:0]         r_frame_cnt;
    logic                  r_blink_phase;

    logic [4*DIGITS-1:0]   r_sh_val, r_act_val;
    logic [DIGITS-1:0]     r_sh_dot, r_act_dot;
    logic [DIGITS-1:0]     r_sh_blink, r_act_blink;
    logic                  r_sh_lz, r_act_lz;
    logic                  r_pending;

    logic                  w_slot_end;
    logic                  w_boundary;
    logic [3:0]            w_phase;
    logic [3:0]            w_nib;
    logic                  w_dot;
    logic                  w_blink;
    logic                  w_lz;
    logic                  w_zero_run;
    logic [DIGITS-1:0]     w_lz_mask;
    logic                  w_visible;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    assign w_slot_end = (r_div_cnt == DW'(SCAN_DIV - 1));
    assign w_boundary = w_slot_end && (r_idx == IW'(DIGITS - 1));
    assign w_phase    = r_div_cnt[DW-1 -: 4];

    // A digit is blanked when it and every digit to its left are zero; digit 0 always stays.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_mask  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_act_val[4*k +: 4] == 4'h0);
            if (k > 0) w_lz_mask[k] = w_zero_run;
        end
    end

    always_comb begin
        w_nib   = '0;
        w_dot   = 1'b0;
        w_blink = 1'b0;
        w_lz    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_idx == IW'(k)) begin
                w_nib   = r_act_val[4*k +: 4];
                w_dot   = r_act_dot[k];
                w_blink = r_act_blink[k];
                w_lz    = w_lz_mask[k];
            end
        end
    end

    assign w_visible = (w_phase <= bright) && !(w_blink && r_blink_phase) && !(r_act_lz && w_lz);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt     <= '0;
            r_idx         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_sh_val      <= '0;
            r_sh_dot      <= '0;
            r_sh_blink    <= '0;
            r_sh_lz       <= 1'b0;
            r_act_val     <= '0;
            r_act_dot     <= '0;
            r_act_blink   <= '0;
            r_act_lz      <= 1'b0;
            r_pending     <= 1'b0;
            seg           <= 7'h7F;
            dp            <= 1'b1;
            an            <= '1;
            frame_done    <= 1'b0;
            upd_ack       <= 1'b0;
        end else begin
            r_div_cnt  <= r_div_cnt + 1'b1;
            if (w_slot_end) r_idx <= w_boundary ? '0 : r_idx + 1'b1;
            frame_done <= w_boundary;
            upd_ack    <= w_boundary && r_pending;

            if (w_boundary) begin
                if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end

            if (w_boundary && r_pending) begin
                r_act_val   <= r_sh_val;
                r_act_dot   <= r_sh_dot;
                r_act_blink <= r_sh_blink;
                r_act_lz    <= r_sh_lz;
                r_pending   <= 1'b0;
            end

            // A load on the boundary edge overrides the pending clear so it lands next frame.
            if (load) begin
                r_sh_val   <= in_val;
                r_sh_dot   <= in_dot;
                r_sh_blink <= in_blink;
                r_sh_lz    <= blank_lz;
                r_pending  <= 1'b1;
            end

            if (w_visible) begin
                an  <= ~(DIGITS'(1) << r_idx);
                seg <= hex7(w_nib);
                dp  <= ~w_dot;
            end else begin
                an  <= '1;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_scan.sv
// tb/tb_hex_display_scan.sv - randomized bench for hex_display_scan against a frame-arithmetic reference model
module tb_hex_display_scan;

    localparam int D0 = 4, S0 = 16, B0 = 2;
    localparam int D1 = 8, S1 = 32, B1 = 3;
    localparam int NCYC = 6000;

    logic        clk = 1'b0;
    logic        rst_n, load, blank_lz;
    logic [3:0]  bright;
    logic [31:0] val;
    logic [7:0]  dot, blk;

    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1, ack0, ack1;
    logic [3:0]  an0;
    logic [7:0]  an1;

    always #5 clk = ~clk;

    hex_display_scan #(.DIGITS(D0), .SCAN_DIV(S0), .BLINK_FRAMES(B0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .in_val(val[15:0]), .in_dot(dot[3:0]),
        .in_blink(blk[3:0]), .blank_lz(blank_lz), .bright(bright), .seg(seg0), .dp(dp0),
        .an(an0), .frame_done(fd0), .upd_ack(ack0));

    hex_display_scan #(.DIGITS(D1), .SCAN_DIV(S1), .BLINK_FRAMES(B1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .in_val(val), .in_dot(dot),
        .in_blink(blk), .blank_lz(blank_lz), .bright(bright), .seg(seg1), .dp(dp1),
        .an(an1), .frame_done(fd1), .upd_ack(ack1));

    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    int          m_cyc     [2];
    logic [31:0] m_sh_val  [2], m_act_val [2];
    logic [7:0]  m_sh_dot  [2], m_act_dot [2];
    logic [7:0]  m_sh_blk  [2], m_act_blk [2];
    logic        m_sh_lz   [2], m_act_lz  [2];
    logic        m_pend    [2];

    // Expected outputs after this edge from the pre-edge model state, then advance the model.
    task automatic model_step(input int m, output logic [7:0] e_an, output logic [6:0] e_seg,
                              output logic e_dp, output logic e_fd, output logic e_ack);
        int d, s, b, div, idx, frames;
        logic bp, lit, boundary;
        logic [7:0] amask;
        logic [31:0] vmask, upper;
        logic [3:0] nib;
        d = (m == 0) ? D0 : D1;
        s = (m == 0) ? S0 : S1;
        b = (m == 0) ? B0 : B1;
        amask = 8'((1 << d) - 1);
        vmask = (d == 8) ? 32'hFFFF_FFFF : ((32'h1 << (4 * d)) - 32'h1);
        if (!rst_n) begin
            e_an = amask; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_ack = 1'b0;
            m_cyc[m] = 0;
            m_sh_val[m] = '0; m_act_val[m] = '0; m_sh_dot[m] = '0; m_act_dot[m] = '0;
            m_sh_blk[m] = '0; m_act_blk[m] = '0; m_sh_lz[m] = 1'b0; m_act_lz[m] = 1'b0;
            m_pend[m] = 1'b0;
        end else begin
            div    = m_cyc[m] % s;
            idx    = (m_cyc[m] / s) % d;
            frames = m_cyc[m] / (d * s);
            bp     = ((frames / b) % 2) == 1;
            upper  = m_act_val[m] >> (4 * idx);
            nib    = upper[3:0];
            lit    = (div / (s / 16)) <= int'(bright);
            if (m_act_blk[m][idx] && bp) lit = 1'b0;
            if (m_act_lz[m] && idx > 0 && upper == 0) lit = 1'b0;
            if (lit) begin
                e_an  = amask & ~(8'd1 << idx);
                e_seg = hex_tab[nib];
                e_dp  = ~m_act_dot[m][idx];
            end else begin
                e_an = amask; e_seg = 7'h7F; e_dp = 1'b1;
            end
            boundary = ((m_cyc[m] + 1) % (d * s)) == 0;
            e_fd  = boundary;
            e_ack = boundary && m_pend[m];
            if (boundary && m_pend[m]) begin
                m_act_val[m] = m_sh_val[m]; m_act_dot[m] = m_sh_dot[m];
                m_act_blk[m] = m_sh_blk[m]; m_act_lz[m]  = m_sh_lz[m];
                m_pend[m] = 1'b0;
            end
            if (load) begin
                m_sh_val[m] = val & vmask; m_sh_dot[m] = dot & amask;
                m_sh_blk[m] = blk & amask; m_sh_lz[m]  = blank_lz;
                m_pend[m] = 1'b1;
            end
            m_cyc[m]++;
        end
    endtask

    initial begin
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_fd, e_ack;
        rst_n = 1'b0; load = 1'b0; blank_lz = 1'b0; bright = 4'hF;
        val = '0; dot = '0; blk = '0;
        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            rst_n = !(t < 3 || (t >= 3000 && t < 3002));
            load  = 1'b0;
            if (t == 100 || t == 300) begin
                load = 1'b1; val = 32'h0000_A5C3; blank_lz = 1'b0; dot = '0; blk = '0;
            end else if (t == 310) begin
                load = 1'b1; val = 32'h0000_0070; blank_lz = 1'b1;
            end else if (t >= 400) begin
                if ($urandom_range(49) == 0) bright = 4'($urandom_range(15));
                if ($urandom_range(59) == 0 ||
                    (((m_cyc[0] + 1) % (D0 * S0)) == 0 && $urandom_range(2) == 0)) begin
                    load = 1'b1;
                    case ($urandom_range(4))
                        0: val = $urandom;
                        1: val = 32'h0000_A5C3;
                        2: val = 32'h0000_0070;
                        3: val = 32'h0;
                        default: val = $urandom & 32'h000F_00F0;
                    endcase
                    blank_lz = 1'($urandom_range(1));
                    dot = 8'($urandom);
                    blk = 8'($urandom);
                end
            end
            @(posedge clk);
            #1;
            model_step(0, e_an, e_seg, e_dp, e_fd, e_ack);
            check($sformatf("an0@%0d", t), 32'(an0), 32'(e_an));
            check($sformatf("seg0@%0d", t), 32'(seg0), 32'(e_seg));
            check($sformatf("dp0@%0d", t), 32'(dp0), 32'(e_dp));
            check($sformatf("fd0@%0d", t), 32'(fd0), 32'(e_fd));
            check($sformatf("ack0@%0d", t), 32'(ack0), 32'(e_ack));
            check($sformatf("an0_onehot@%0d", t), 32'($countones(~an0) <= 1), 32'd1);
            model_step(1, e_an, e_seg, e_dp, e_fd, e_ack);
            check($sformatf("an1@%0d", t), 32'(an1), 32'(e_an));
            check($sformatf("seg1@%0d", t), 32'(seg1), 32'(e_seg));
            check($sformatf("dp1@%0d", t), 32'(dp1), 32'(e_dp));
            check($sformatf("fd1@%0d", t), 32'(fd1), 32'(e_fd));
            check($sformatf("ack1@%0d", t), 32'(ack1), 32'(e_ack));
            check($sformatf("an1_onehot@%0d", t), 32'($countones(~an1) <= 1), 32'd1);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
